// File: rtl/model_ddr_packer.sv
// model_ddr_packer
// Packs the 16-bit SD model-sector write stream into MEM_DW-wide words,
// buffers them in a small FIFO and writes them sequentially to a req/ack
// memory port starting at base_addr. The input has no backpressure: when
// every slot is taken the packed word is dropped and overflow is flagged.
// The word currently presented on the memory port keeps its FIFO slot until
// it is acked, so at most FIFO_DEPTH words are held in total.
module model_ddr_packer #(
    parameter int IN_DW      = 16,
    parameter int MEM_DW     = 128,
    parameter int ADDR_W     = 28,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_en,
    input  logic [IN_DW-1:0]  in_data,
    input  logic              in_last,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [MEM_DW-1:0] mem_wr_data,
    input  logic              mem_wr_ack,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [31:0]       words_written
);

    localparam int LANES  = MEM_DW / IN_DW;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(MEM_DW / 8);

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_REQ  = 1'b1
    } wstate_t;

    // Input side
    logic              in_open;
    logic              active;
    logic [LANE_W-1:0] lane;
    logic [MEM_DW-1:0] pack_buf;
    logic [MEM_DW-1:0] word_next;
    logic              beat_take;
    logic              push;
    logic              push_ok;
    logic              drop;

    // FIFO
    logic [MEM_DW-1:0] fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  occupancy;
    logic              fifo_empty;
    logic              slots_full;

    // Writer
    wstate_t           state;
    wstate_t           state_nx;
    logic              pop;
    logic              ack_take;
    logic              req_last;
    logic [ADDR_W-1:0] next_addr;

    // start always wins over a beat arriving in the same cycle
    assign beat_take  = in_en && in_open && !start;
    assign push       = beat_take && ((lane == LAST_LANE) || in_last);
    assign fifo_empty = (fifo_cnt == '0);
    assign occupancy  = fifo_cnt + {{(CNT_W-1){1'b0}}, (state == W_REQ)};
    assign slots_full = (occupancy == FULL_CNT);
    assign ack_take   = (state == W_REQ) && mem_wr_ack && !start;
    // an ack in the same cycle frees the in-flight slot, so the push still fits
    assign push_ok    = push && (!slots_full || ack_take);
    assign drop       = push && slots_full && !ack_take;

    assign mem_wr_req = (state == W_REQ);
    assign busy       = active && !done;

    // Merge the incoming beat into its lane; unfilled upper lanes stay zero
    always_comb begin
        word_next = pack_buf;
        word_next[int'(lane)*IN_DW +: IN_DW] = in_data;
    end

    // Lane counter, partial-word buffer and input arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_open  <= 1'b0;
            lane     <= '0;
            pack_buf <= '0;
        end else if (start) begin
            in_open  <= 1'b1;
            lane     <= '0;
            pack_buf <= '0;
        end else if (beat_take) begin
            if (push) begin
                lane     <= '0;
                pack_buf <= '0;
                if (in_last) begin
                    in_open <= 1'b0;
                end
            end else begin
                lane     <= lane + LANE_W'(1);
                pack_buf <= word_next;
            end
        end
    end

    // FIFO storage (contents need no reset; pointers and count gate all reads)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= word_next;
            fifo_last[wr_ptr] <= in_last;
        end
    end

    // FIFO pointers and word count; start flushes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Writer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= W_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Writer next state and FIFO pop; acked words chain back-to-back
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        if (start) begin
            state_nx = W_IDLE;
        end else begin
            case (state)
                W_IDLE: begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_nx = W_REQ;
                    end
                end
                W_REQ: begin
                    if (mem_wr_ack) begin
                        if (req_last) begin
                            state_nx = W_IDLE;
                        end else if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_nx = W_IDLE;
                        end
                    end
                end
                default: state_nx = W_IDLE;
            endcase
        end
    end

    // Memory port registers, address/count bookkeeping and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
            req_last      <= 1'b0;
            next_addr     <= '0;
            words_written <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            active        <= 1'b0;
        end else if (start) begin
            req_last      <= 1'b0;
            next_addr     <= base_addr;
            words_written <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            active        <= 1'b1;
        end else begin
            if (pop) begin
                mem_wr_data <= fifo_data[rd_ptr];
                req_last    <= fifo_last[rd_ptr];
                mem_wr_addr <= next_addr;
                next_addr   <= next_addr + ADDR_STEP;
            end
            if (ack_take) begin
                words_written <= words_written + 32'd1;
                if (req_last) begin
                    done <= 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
